// File: rtl/gpio_input_capture.sv
// -----------------------------------------------------------------------------
// gpio_input_capture
//
// Input conditioning path for the GPIO block. Every raw pad bit is brought into
// the sys_clk domain through a SYNC_STAGES-deep synchroniser. It is then
// optionally debounced and published on gpio_data_in. A change of the clean
// value sets a sticky per-bit status flag when the matching rise/fall enable is
// set. Status bits are masked and ORed onto a single level interrupt.
//
// Optional feature macro:
//   GPIO_DEBOUNCE_EN  When defined, this compiles in a shared debounce
//                     prescaler and per-bit debounce counters. When it is not
//                     defined, the clean value is the last synchroniser stage,
//                     and DB_PRESCALE / DB_COUNT have no effect.
//
// Parameters:
//   WIDTH        number of GPIO bits
//   SYNC_STAGES  synchroniser depth per bit (2..4)
//   DB_PRESCALE  sys_clk cycles per debounce sample tick (>= 2)
//   DB_COUNT     consecutive differing ticks needed to accept a level (2..15)
//
// Ports:
//   sys_clk       sole clock; all state changes on the rising edge
//   sys_rst_n     asynchronous active-low reset
//   pad_in        raw pad values, asynchronous to sys_clk
//   gpio_oe       1 = pin drives out; edge events on that bit are suppressed
//   irq_rise_en   per-bit enable for 0->1 events on the clean value
//   irq_fall_en   per-bit enable for 1->0 events on the clean value
//   irq_mask      1 = the status bit contributes to irq
//   irq_clr       write-1-to-clear strobe for irq_status
//   gpio_data_in  clean input value
//   irq_status    sticky per-bit event flags
//   irq           |(irq_status & irq_mask); a register-driven combinational output
// -----------------------------------------------------------------------------
module gpio_input_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DB_PRESCALE = 16,
  parameter int DB_COUNT    = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [WIDTH-1:0] pad_in,
  input  logic [WIDTH-1:0] gpio_oe,
  input  logic [WIDTH-1:0] irq_rise_en,
  input  logic [WIDTH-1:0] irq_fall_en,
  input  logic [WIDTH-1:0] irq_mask,
  input  logic [WIDTH-1:0] irq_clr,
  output logic [WIDTH-1:0] gpio_data_in,
  output logic [WIDTH-1:0] irq_status,
  output logic             irq
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks. Illegal settings stop the build instead
  // of producing silently wrong hardware.
  // ---------------------------------------------------------------------------
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("gpio_input_capture: SYNC_STAGES must be 2..4");
  end
  if (DB_PRESCALE < 2) begin : g_bad_db_prescale
    $error("gpio_input_capture: DB_PRESCALE must be >= 2");
  end
  if (DB_COUNT < 2 || DB_COUNT > 15) begin : g_bad_db_count
    $error("gpio_input_capture: DB_COUNT must be 2..15");
  end

  // The arm counter saturates at SYNC_STAGES+1. By then, the synchroniser and
  // the stable register both hold real pad data rather than reset zeros.
  localparam int ARM_MAX = SYNC_STAGES + 1;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  // ---------------------------------------------------------------------------
  // Synchroniser chain: a plain flop chain per bit, with no logic between stages.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0]                  sync_last;

  always_comb begin
    sync_d[0] = pad_in;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end
  end

  // NOTE: sequential blocks use non-blocking assignments only. All flops then
  // sample their inputs at the same instant, whatever order the blocks run in.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Arming counter. After reset it counts up and then holds. While the block
  // is unarmed, the stable register follows the synchroniser directly and no
  // events are generated. The reset-to-pad transition therefore never looks
  // like an edge.
  // ---------------------------------------------------------------------------
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic             armed;

  assign armed = (arm_cnt_q == ARM_W'(ARM_MAX));

  always_comb begin
    arm_cnt_d = arm_cnt_q;
    if (!armed) begin
      arm_cnt_d = arm_cnt_q + ARM_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      arm_cnt_q <= '0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stable (clean) value. stable_d is the value loaded this cycle. Edge
  // detection compares it with the current stable_q, so an event and the data
  // change land on the same clock edge.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] stable_q, stable_d;

`ifdef GPIO_DEBOUNCE_EN
  localparam int PS_W = $clog2(DB_PRESCALE);
  localparam int DC_W = $clog2(DB_COUNT);

  // Shared prescaler. It counts 0..DB_PRESCALE-1 and emits a one-cycle tick
  // at the terminal count.
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  assign tick = (ps_q == PS_W'(DB_PRESCALE - 1));

  always_comb begin
    ps_d = ps_q + PS_W'(1);
    if (tick) begin
      ps_d = '0;
    end
  end

  // Per-bit debounce counters. A counter advances only on ticks where the
  // synchronised value differs from stable. It is cleared as soon as the two
  // agree, so a level that reverts early loses its partial count.
  logic [WIDTH-1:0][DC_W-1:0] db_cnt_q, db_cnt_d;

  // NOTE: every signal written in this always_comb gets a default value first.
  // Any path that skips an assignment then keeps the default instead of
  // inferring a latch.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (!armed) begin
        // Debounce is bypassed until armed. The clean value settles on the
        // real pad level and carries no stale partial count.
        stable_d[i] = sync_last[i];
        db_cnt_d[i] = '0;
      end else if (sync_last[i] == stable_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (tick) begin
        if (db_cnt_q[i] == DC_W'(DB_COUNT - 1)) begin
          // This is the DB_COUNT-th consecutive differing tick: accept the level.
          stable_d[i] = sync_last[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DC_W'(1);
        end
      end
    end
  end

  // NOTE: the per-bit counter array is reset like any other state. A reset in
  // the middle of debouncing must discard all partial counts.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ps_q     <= '0;
      db_cnt_q <= '0;
    end else begin
      ps_q     <= ps_d;
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  // Without debounce, the clean value is simply the last synchroniser stage.
  always_comb begin
    stable_d = sync_last;
  end
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      stable_q <= '0;
    end else begin
      stable_q <= stable_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Edge detection and sticky status.
  // gpio_oe suppresses events but not data. Output pins still read back their
  // own level on gpio_data_in.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] ev_gate;
  logic [WIDTH-1:0] rise, fall;
  logic [WIDTH-1:0] irq_status_q, irq_status_d;

  always_comb begin
    ev_gate = ~gpio_oe & {WIDTH{armed}};
    rise    = ~stable_q &  stable_d & irq_rise_en & ev_gate;
    fall    =  stable_q & ~stable_d & irq_fall_en & ev_gate;
    // A new event in the same cycle as a clear wins. The event is never lost.
    irq_status_d = (irq_status_q & ~irq_clr) | rise | fall;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      irq_status_q <= '0;
    end else begin
      irq_status_q <= irq_status_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gpio_data_in = stable_q;
  assign irq_status   = irq_status_q;
  assign irq          = |(irq_status_q & irq_mask);

endmodule
